// File: rtl/print_pkg.sv
// Shared widths and FSM state encoding for the message print path.
// The request driver and msg_print_engine both take their default widths from here.
package print_pkg;

  localparam int unsigned PrintAddrW = 7;  // message ROM address width
  localparam int unsigned PrintDataW = 8;  // byte width of ROM, bypass and tx data

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StLoad  = 2'd2,
    StSend  = 2'd3
  } print_state_e;

endpackage

// File: rtl/msg_print_engine.sv
// Message print engine: takes a request for an inclusive ROM address range (or a
// single bypass byte), reads each byte from a synchronous message ROM, and streams
// the bytes to a UART transmitter over a valid/ready handshake.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   addr_start_i   first ROM address of the range (inclusive)
//   addr_end_i     last ROM address of the range (inclusive); end < start wraps
//   en_i           request strobe, sampled only while ready_o is high
//   bypass_i       with en_i: send bypass_data_i instead of reading the ROM
//   bypass_data_i  byte sent for a bypass request
//   ready_o        engine idle and able to accept a request
//   mem_addr_o     ROM read address (registered)
//   mem_en_o       ROM read enable, one cycle per byte
//   mem_data_i     ROM data, valid the cycle after mem_en_o
//   tx_data_o      byte to the UART
//   tx_valid_o     tx_data_o valid
//   tx_ready_i     UART accepts; transfer when tx_valid_o && tx_ready_i
module msg_print_engine
  import print_pkg::*;
#(
  parameter int unsigned ADDR_W = PrintAddrW,
  parameter int unsigned DATA_W = PrintDataW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_start_i,
  input  logic [ADDR_W-1:0] addr_end_i,
  input  logic              en_i,
  input  logic              bypass_i,
  input  logic [DATA_W-1:0] bypass_data_i,
  output logic              ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_en_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i
);

  print_state_e      state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] end_q;
  logic              last_q;   // current byte is a bypass byte
  logic [ADDR_W-1:0] cur_inc;

  // Natural modulo-2**ADDR_W wrap gives the end < start behaviour.
  assign cur_inc = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign ready_o = (state_q == StIdle);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      end_q      <= '0;
      last_q     <= 1'b0;
      mem_addr_o <= '0;
      mem_en_o   <= 1'b0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
    end else begin
      // Read enable is a single-cycle pulse raised on every entry to StFetch.
      mem_en_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en_i) begin
            if (bypass_i) begin
              tx_data_o  <= bypass_data_i;
              tx_valid_o <= 1'b1;
              last_q     <= 1'b1;
              state_q    <= StSend;
            end else begin
              cur_q      <= addr_start_i;
              end_q      <= addr_end_i;
              last_q     <= 1'b0;
              mem_addr_o <= addr_start_i;
              mem_en_o   <= 1'b1;
              state_q    <= StFetch;
            end
          end
        end
        StFetch: begin
          state_q <= StLoad;
        end
        StLoad: begin
          tx_data_o  <= mem_data_i;
          tx_valid_o <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            if (last_q || (cur_q == end_q)) begin
              state_q <= StIdle;
            end else begin
              cur_q      <= cur_inc;
              mem_addr_o <= cur_inc;
              mem_en_o   <= 1'b1;
              state_q    <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
